// File: rtl/elevator_dispatch.sv
// ----------------------------------------------------------------------------
// elevator_dispatch
// Four-floor elevator scheduler. It latches floor calls, picks a direction,
// stops at called floors, holds the door open for DOOR_TICKS en ticks and
// then continues in the preferred direction, reverses, or goes idle.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   en         step-tick enable; scheduling decisions only on en edges
//   F          floor call buttons (active-high, any combination)
//   at_floor   one-hot car position, 0 = between floors
//   tgt        one-hot target floor (MOVE states only, else 0)
//   up / dn    motor commands
//   door_open  door command
//   pending    latched outstanding calls
//   busy       high in any state other than IDLE
//   state_dbg  current FSM state encoding, for observation only
//
// Handshake: there is no valid/ready pair. F is sampled on every clk edge,
// and the decision inputs (at_floor, pending) are acted on only when en=1.
// ----------------------------------------------------------------------------
module elevator_dispatch #(
    parameter int DOOR_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] F,
    input  logic [3:0] at_floor,
    output logic [3:0] tgt,
    output logic       up,
    output logic       dn,
    output logic       door_open,
    output logic [3:0] pending,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(DOOR_TICKS - 1);

    state_t     state, state_nxt;
    logic       dir, dir_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] door_flr, door_flr_nxt;
    logic [1:0] pos, pos_nxt;
    logic [3:0] pending_nxt, clr, tgt_nxt;
    logic       af_valid;
    logic [1:0] af_idx;

    // Any pending call strictly above / below floor k.
    function automatic logic has_above(input logic [3:0] p, input logic [1:0] k);
        return |(p & (4'b1110 << k));
    endfunction

    function automatic logic has_below(input logic [3:0] p, input logic [1:0] k);
        return |(p & ((4'b0001 << k) - 4'b0001));
    endfunction

    // Nearest pending floor strictly above k (lowest such bit).
    function automatic logic [3:0] nearest_up(input logic [3:0] p, input logic [1:0] k);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 3; i >= 0; i--)
            if (i > int'(k) && p[i]) r = 4'b0001 << i;
        return r;
    endfunction

    // Nearest pending floor strictly below k (highest such bit).
    function automatic logic [3:0] nearest_dn(input logic [3:0] p, input logic [1:0] k);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i < int'(k) && p[i]) r = 4'b0001 << i;
        return r;
    endfunction

    // A non-one-hot at_floor is treated as "between floors".
    always_comb begin
        af_valid = 1'b1;
        af_idx   = 2'd0;
        case (at_floor)
            4'b0001: af_idx = 2'd0;
            4'b0010: af_idx = 2'd1;
            4'b0100: af_idx = 2'd2;
            4'b1000: af_idx = 2'd3;
            default: af_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir;
        cnt_nxt      = cnt;
        door_flr_nxt = door_flr;
        pos_nxt      = af_valid ? af_idx : pos;
        clr          = 4'b0000;
        case (state)
            IDLE: begin
                if (en && af_valid) begin
                    if (pending[af_idx]) begin
                        state_nxt    = DOOR;
                        door_flr_nxt = af_idx;
                        cnt_nxt      = CNT_LOAD;
                    end else if (has_above(pending, af_idx) &&
                                 (dir || !has_below(pending, af_idx))) begin
                        state_nxt = MOVE_UP;
                        dir_nxt   = 1'b1;
                    end else if (has_below(pending, af_idx)) begin
                        state_nxt = MOVE_DN;
                        dir_nxt   = 1'b0;
                    end
                end
            end
            MOVE_UP, MOVE_DN: begin
                if (en && af_valid) begin
                    if (pending[af_idx]) begin
                        state_nxt    = DOOR;
                        door_flr_nxt = af_idx;
                        cnt_nxt      = CNT_LOAD;
                    end else if ((state == MOVE_UP) ? !has_above(pending, af_idx)
                                                    : !has_below(pending, af_idx)) begin
                        // Nothing left ahead at a real floor: stop rather than run off the end.
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR: begin
                // A re-press of this floor restarts the door hold, en or not.
                if (F[door_flr]) begin
                    cnt_nxt = CNT_LOAD;
                end else if (en) begin
                    if (cnt != 4'd0) begin
                        cnt_nxt = cnt - 4'd1;
                    end else if (dir && has_above(pending, door_flr)) begin
                        state_nxt = MOVE_UP;
                    end else if (!dir && has_below(pending, door_flr)) begin
                        state_nxt = MOVE_DN;
                    end else if (dir && has_below(pending, door_flr)) begin
                        state_nxt = MOVE_DN;
                        dir_nxt   = 1'b0;
                    end else if (!dir && has_above(pending, door_flr)) begin
                        state_nxt = MOVE_UP;
                        dir_nxt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // While the door is (or is becoming) open, its floor's call is cleared,
        // winning over a press in the same cycle.
        if (state_nxt == DOOR) clr = 4'b0001 << door_flr_nxt;
        pending_nxt = (pending | F) & ~clr;

        case (state_nxt)
            MOVE_UP: tgt_nxt = nearest_up(pending_nxt, pos_nxt);
            MOVE_DN: tgt_nxt = nearest_dn(pending_nxt, pos_nxt);
            default: tgt_nxt = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= 1'b1;
            cnt       <= 4'd0;
            door_flr  <= 2'd0;
            pos       <= 2'd0;
            pending   <= 4'b0000;
            tgt       <= 4'b0000;
            up        <= 1'b0;
            dn        <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dir       <= dir_nxt;
            cnt       <= cnt_nxt;
            door_flr  <= door_flr_nxt;
            pos       <= pos_nxt;
            pending   <= pending_nxt;
            tgt       <= tgt_nxt;
            up        <= (state_nxt == MOVE_UP);
            dn        <= (state_nxt == MOVE_DN);
            door_open <= (state_nxt == DOOR);
            busy      <= (state_nxt != IDLE);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_elevator_dispatch.sv
// ----------------------------------------------------------------------------
// tb_elevator_dispatch
// Directed scenarios with hand-computed expectations, followed by a short
// random run checking output invariants. Inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
// ----------------------------------------------------------------------------
module tb_elevator_dispatch;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] F;
  logic [3:0] at_floor;
  logic [3:0] tgt;
  logic       up;
  logic       dn;
  logic       door_open;
  logic [3:0] pending;
  logic       busy;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  elevator_dispatch #(.DOOR_TICKS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .F         (F),
    .at_floor  (at_floor),
    .tgt       (tgt),
    .up        (up),
    .dn        (dn),
    .door_open (door_open),
    .pending   (pending),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step(input logic [3:0] f, input logic [3:0] af);
    F = f;
    at_floor = af;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] af);
    reset = 1'b1;
    en = 1'b1;
    F = 4'b0000;
    at_floor = af;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Door was just entered (first open observation done): three more open
  // observations, then the next decision edge leaves to IDLE.
  task automatic finish_door(input string tag, input logic [3:0] af);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, af);
      check({tag, "_door_hold"}, 32'(door_open), 32'd1);
    end
    step(4'b0000, af);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_door"}, 32'(door_open), 32'd0);
  endtask

  logic [3:0] af_tab [6];

  initial begin
    reset = 1'b1;
    en = 1'b0;
    F = 4'b0000;
    at_floor = 4'b0001;
    #1;
    check("rst_up", 32'(up), 32'd0);
    check("rst_dn", 32'(dn), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_tgt", 32'(tgt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    do_reset(4'b0001);

    // single call above, car at floor 0
    step(4'b0100, 4'b0001);
    check("t27_pending", 32'(pending), 32'h4);
    check("t27_up0", 32'(up), 32'd0);
    step(4'b0000, 4'b0001);
    check("t27_up", 32'(up), 32'd1);
    check("t27_dn", 32'(dn), 32'd0);
    check("t27_tgt", 32'(tgt), 32'h4);
    check("t27_busy", 32'(busy), 32'd1);
    step(4'b0000, 4'b0000);
    check("t27_between_up", 32'(up), 32'd1);
    check("t27_between_tgt", 32'(tgt), 32'h4);
    step(4'b0000, 4'b0100);
    check("t27_door", 32'(door_open), 32'd1);
    check("t27_stop_up", 32'(up), 32'd0);
    check("t27_clr", 32'(pending), 32'h0);
    check("t27_door_tgt", 32'(tgt), 32'h0);
    finish_door("t27", 4'b0100);
    check("t27_state", 32'(state_dbg), 32'd0);

    // en low: calls latch, no decision
    en = 1'b0;
    step(4'b0010, 4'b0100);
    check("t30_pending", 32'(pending), 32'h2);
    check("t30_busy", 32'(busy), 32'd0);
    step(4'b0000, 4'b0100);
    step(4'b0000, 4'b0100);
    check("t30_up", 32'(up), 32'd0);
    check("t30_dn", 32'(dn), 32'd0);
    check("t30_hold_busy", 32'(busy), 32'd0);
    en = 1'b1;
    step(4'b0000, 4'b0100);
    check("t30_dn_go", 32'(dn), 32'd1);
    check("t30_tgt", 32'(tgt), 32'h2);
    step(4'b0000, 4'b0010);
    check("t30_door", 32'(door_open), 32'd1);
    check("t30_clr", 32'(pending), 32'h0);
    finish_door("t30", 4'b0010);

    // two calls from floor 1, default direction up
    do_reset(4'b0010);
    step(4'b1001, 4'b0010);
    check("t28_pending", 32'(pending), 32'h9);
    step(4'b0000, 4'b0010);
    check("t28_up", 32'(up), 32'd1);
    check("t28_tgt_up", 32'(tgt), 32'h8);
    step(4'b0000, 4'b0100);
    check("t28_pass2", 32'(up), 32'd1);
    step(4'b0000, 4'b1000);
    check("t28_door3", 32'(door_open), 32'd1);
    check("t28_pend3", 32'(pending), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 4'b1000);
      check("t28_door3_hold", 32'(door_open), 32'd1);
    end
    step(4'b0000, 4'b1000);
    check("t28_rev_dn", 32'(dn), 32'd1);
    check("t28_rev_up", 32'(up), 32'd0);
    check("t28_tgt_dn", 32'(tgt), 32'h1);
    step(4'b0000, 4'b0100);
    check("t28_tgt_mid", 32'(tgt), 32'h1);
    step(4'b0000, 4'b0010);
    step(4'b0000, 4'b0001);
    check("t28_door0", 32'(door_open), 32'd1);
    check("t28_clr0", 32'(pending), 32'h0);
    finish_door("t28", 4'b0001);

    // call at floor 0 while there: opens, never moves down
    step(4'b0001, 4'b0001);
    step(4'b0000, 4'b0001);
    check("b0_door", 32'(door_open), 32'd1);
    check("b0_dn", 32'(dn), 32'd0);
    finish_door("b0", 4'b0001);

    // door re-press, with press held across door entry
    step(4'b0100, 4'b0100);
    check("t29_pending", 32'(pending), 32'h4);
    step(4'b0100, 4'b0100);
    check("t29_door", 32'(door_open), 32'd1);
    check("t29_clr_prio", 32'(pending), 32'h0);
    step(4'b0000, 4'b0100);
    check("t29_tick2", 32'(door_open), 32'd1);
    step(4'b0100, 4'b0100);
    check("t29_reload", 32'(door_open), 32'd1);
    check("t29_keep_clr", 32'(pending), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 4'b0100);
      check("t29_more", 32'(door_open), 32'd1);
      check("t29_more_clr", 32'(pending), 32'h0);
    end
    step(4'b0000, 4'b0100);
    check("t29_idle", 32'(busy), 32'd0);

    // call at floor 3 while there: opens, never moves up
    step(4'b1000, 4'b1000);
    step(4'b0000, 4'b1000);
    check("b3_door", 32'(door_open), 32'd1);
    check("b3_up", 32'(up), 32'd0);
    finish_door("b3", 4'b1000);

    // malformed at_floor is "between floors"
    do_reset(4'b0110);
    step(4'b0001, 4'b0110);
    check("t23_pending", 32'(pending), 32'h1);
    step(4'b0000, 4'b0110);
    check("t23_no_depart", 32'(busy), 32'd0);
    step(4'b0000, 4'b0100);
    check("t23_dn", 32'(dn), 32'd1);
    check("t23_tgt", 32'(tgt), 32'h1);
    step(4'b0000, 4'b0011);
    check("t23_no_stop", 32'(dn), 32'd1);
    check("t23_no_door", 32'(door_open), 32'd0);
    step(4'b0000, 4'b0001);
    check("t23_door", 32'(door_open), 32'd1);
    finish_door("t23", 4'b0001);

    // asynchronous reset mid-move
    do_reset(4'b0001);
    step(4'b1010, 4'b0001);
    check("t31_pending", 32'(pending), 32'ha);
    step(4'b0000, 4'b0001);
    check("t31_up", 32'(up), 32'd1);
    check("t31_tgt", 32'(tgt), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("t31_rst_up", 32'(up), 32'd0);
    check("t31_rst_pending", 32'(pending), 32'h0);
    check("t31_rst_tgt", 32'(tgt), 32'h0);
    check("t31_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // random run, invariants only
    af_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110};
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
           af_tab[$urandom_range(0, 5)]);
      check("rnd_up_dn", 32'(up & dn), 32'd0);
      check("rnd_door_motor", 32'(door_open & (up | dn)), 32'd0);
      check("rnd_tgt_onehot0", 32'((tgt & (tgt - 4'd1)) != 4'd0), 32'd0);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
